ph1_coeff_loader: RTL and testbench



---
 rtl/ph1_cfg_pkg.sv | 48 ++++
 rtl/ph1_coeff_loader.sv | 157 +++++++++++++++
 tb/tb_ph1_coeff_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ph1_cfg_pkg.sv
// Shared address map, group/state encodings and the coefficient Q-format for the
// Phase-1 DFE coefficient loader.
package ph1_cfg_pkg;

  localparam int ADDR_W      = 8;
  localparam int COEFF_FRAC  = 18;

  localparam int TAP_BASE    = 0;
  localparam int TAP_SIZE    = 72;
  localparam int NUM_SIZE    = 3;
  localparam int DEN_SIZE    = 2;
  localparam int NUM24_BASE  = 72;
  localparam int DEN24_BASE  = 75;
  localparam int NUM2_BASE   = 77;
  localparam int DEN2_BASE   = 80;
  localparam int NUM1_BASE   = 82;
  localparam int DEN1_BASE   = 85;
  localparam int BYPASS_ADDR = 87;
  localparam int ADDR_LIMIT  = 88;
  localparam int NUM_GROUPS  = 7;

  typedef enum logic [2:0] {
    G_FRAC  = 3'd0,
    G_NUM24 = 3'd1,
    G_DEN24 = 3'd2,
    G_NUM2  = 3'd3,
    G_DEN2  = 3'd4,
    G_NUM1  = 3'd5,
    G_DEN1  = 3'd6
  } group_e;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_e;

  // Caller guarantees a < BYPASS_ADDR.
  function automatic group_e addr_group(input int a);
    if (a < NUM24_BASE)      return G_FRAC;
    else if (a < DEN24_BASE) return G_NUM24;
    else if (a < NUM2_BASE)  return G_DEN24;
    else if (a < DEN2_BASE)  return G_NUM2;
    else if (a < NUM1_BASE)  return G_DEN2;
    else if (a < DEN1_BASE)  return G_NUM1;
    else                     return G_DEN1;
  endfunction

endpackage

// File: rtl/ph1_coeff_loader.sv
// Shadow-register coefficient loader for the Phase-1 DFE chain: addressed writes
// fill the shadows, a commit walks the seven groups issuing write pulses for dirty ones.
module ph1_coeff_loader
  import ph1_cfg_pkg::*;
#(
  parameter int COEFF_WIDTH     = 20,
  parameter int N_TAP           = 72,
  parameter int NUM_COEFF_DEPTH = 3,
  parameter int DEN_COEFF_DEPTH = 2,
  parameter int ADDR_WIDTH      = ADDR_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [ADDR_WIDTH-1:0]                  cfg_addr,
  input  logic [COEFF_WIDTH-1:0]                 cfg_data,
  input  logic                                   cfg_commit,
  output logic                                   cfg_err,
  output logic                                   busy,
  output logic                                   frac_dec_coeff_wr_en,
  output logic [COEFF_WIDTH*N_TAP-1:0]           frac_dec_coeff_data_out,
  output logic                                   iir_num_coeff_2_4_wr_en,
  output logic                                   iir_den_coeff_2_4_wr_en,
  output logic                                   iir_num_coeff_2_wr_en,
  output logic                                   iir_den_coeff_2_wr_en,
  output logic                                   iir_num_coeff_1_wr_en,
  output logic                                   iir_den_coeff_1_wr_en,
  output logic [COEFF_WIDTH*NUM_COEFF_DEPTH-1:0] iir_num_coeff_2_4_out,
  output logic [COEFF_WIDTH*NUM_COEFF_DEPTH-1:0] iir_num_coeff_2_out,
  output logic [COEFF_WIDTH*NUM_COEFF_DEPTH-1:0] iir_num_coeff_1_out,
  output logic [COEFF_WIDTH*DEN_COEFF_DEPTH-1:0] iir_den_coeff_2_4_out,
  output logic [COEFF_WIDTH*DEN_COEFF_DEPTH-1:0] iir_den_coeff_2_out,
  output logic [COEFF_WIDTH*DEN_COEFF_DEPTH-1:0] iir_den_coeff_1_out,
  output logic                                   iir_bypass_2_4,
  output logic                                   iir_bypass_2,
  output logic                                   iir_bypass_1
);

  // The shadow layout is fixed by the package address map.
  if (N_TAP != TAP_SIZE || NUM_COEFF_DEPTH != NUM_SIZE ||
      DEN_COEFF_DEPTH != DEN_SIZE || COEFF_FRAC >= COEFF_WIDTH) begin : g_bad_cfg
    $error("ph1_coeff_loader: parameters disagree with ph1_cfg_pkg address map");
  end

  localparam logic [ADDR_WIDTH-1:0] A_BYP = ADDR_WIDTH'(BYPASS_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_LIM = ADDR_WIDTH'(ADDR_LIMIT);

  state_e                        state_q;
  group_e                        grp_q;
  logic [NUM_GROUPS-1:0]         dirty_q, dirty_d;
  logic                          byp_pend_q, byp_pend_d;
  logic [2:0]                    byp_shadow_q, byp_shadow_d;
  logic [2:0]                    bypass_q;
  logic                          err_q;
  logic signed [COEFF_WIDTH-1:0] coef_q [BYPASS_ADDR];
  logic [NUM_GROUPS-1:0]         wr_pulse;

  logic wr_acc, commit_acc, wr_coef, wr_byp, wr_bad;

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q == WALK);
  assign wr_acc     = cfg_valid && cfg_ready;
  assign commit_acc = cfg_commit && cfg_ready;
  assign wr_coef    = wr_acc && (cfg_addr < A_BYP);
  assign wr_byp     = wr_acc && (cfg_addr == A_BYP);
  assign wr_bad     = wr_acc && (cfg_addr >= A_LIM);

  // Writes are blocked while walking, so set and clear never collide.
  always_comb begin
    dirty_d      = dirty_q;
    byp_pend_d   = byp_pend_q | wr_byp;
    byp_shadow_d = wr_byp ? cfg_data[2:0] : byp_shadow_q;
    if (wr_coef) dirty_d[addr_group(int'(cfg_addr))] = 1'b1;
    if (state_q == WALK) dirty_d[grp_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grp_q        <= G_FRAC;
      dirty_q      <= '0;
      byp_pend_q   <= 1'b0;
      byp_shadow_q <= '0;
      bypass_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q        <= wr_bad;
      dirty_q      <= dirty_d;
      byp_shadow_q <= byp_shadow_d;
      byp_pend_q   <= byp_pend_d;
      case (state_q)
        IDLE: begin
          if (commit_acc) begin
            state_q <= WALK;
            grp_q   <= G_FRAC;
            // Bypass flags go live together with the first group pulse.
            if (byp_pend_d) begin
              bypass_q   <= byp_shadow_d;
              byp_pend_q <= 1'b0;
            end
          end
        end
        WALK: begin
          if (grp_q == G_DEN1) begin
            state_q <= IDLE;
            grp_q   <= G_FRAC;
          end else begin
            grp_q <= group_e'(grp_q + 3'd1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BYPASS_ADDR; i++) coef_q[i] <= '0;
    end else if (wr_coef) begin
      for (int i = 0; i < BYPASS_ADDR; i++)
        if (cfg_addr == ADDR_WIDTH'(i)) coef_q[i] <= cfg_data;
    end
  end

  assign wr_pulse = (state_q == WALK) ? (dirty_q & (NUM_GROUPS'(1) << grp_q)) : '0;

  assign frac_dec_coeff_wr_en    = wr_pulse[G_FRAC];
  assign iir_num_coeff_2_4_wr_en = wr_pulse[G_NUM24];
  assign iir_den_coeff_2_4_wr_en = wr_pulse[G_DEN24];
  assign iir_num_coeff_2_wr_en   = wr_pulse[G_NUM2];
  assign iir_den_coeff_2_wr_en   = wr_pulse[G_DEN2];
  assign iir_num_coeff_1_wr_en   = wr_pulse[G_NUM1];
  assign iir_den_coeff_1_wr_en   = wr_pulse[G_DEN1];

  assign cfg_err        = err_q;
  assign iir_bypass_2_4 = bypass_q[0];
  assign iir_bypass_2   = bypass_q[1];
  assign iir_bypass_1   = bypass_q[2];

  for (genvar k = 0; k < N_TAP; k++) begin : g_tap
    assign frac_dec_coeff_data_out[k*COEFF_WIDTH +: COEFF_WIDTH] = coef_q[TAP_BASE+k];
  end

  for (genvar k = 0; k < NUM_COEFF_DEPTH; k++) begin : g_num
    assign iir_num_coeff_2_4_out[k*COEFF_WIDTH +: COEFF_WIDTH] = coef_q[NUM24_BASE+k];
    assign iir_num_coeff_2_out[k*COEFF_WIDTH +: COEFF_WIDTH]   = coef_q[NUM2_BASE+k];
    assign iir_num_coeff_1_out[k*COEFF_WIDTH +: COEFF_WIDTH]   = coef_q[NUM1_BASE+k];
  end

  for (genvar k = 0; k < DEN_COEFF_DEPTH; k++) begin : g_den
    assign iir_den_coeff_2_4_out[k*COEFF_WIDTH +: COEFF_WIDTH] = coef_q[DEN24_BASE+k];
    assign iir_den_coeff_2_out[k*COEFF_WIDTH +: COEFF_WIDTH]   = coef_q[DEN2_BASE+k];
    assign iir_den_coeff_1_out[k*COEFF_WIDTH +: COEFF_WIDTH]   = coef_q[DEN1_BASE+k];
  end

endmodule

// File: tb/tb_ph1_coeff_loader.sv
// Scoreboard bench for ph1_coeff_loader: stimulus pushes expected pulse/error events,
// a negedge monitor matches them against the DUT outputs.
module tb_ph1_coeff_loader;

  localparam int W     = 20;
  localparam int WORDS = 87;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_commit = 1'b0;
  logic [7:0] cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic cfg_ready, cfg_err, busy;
  logic frac_we, n24_we, d24_we, n2_we, d2_we, n1_we, d1_we;
  logic [W*72-1:0] frac_out;
  logic [W*3-1:0] n24_out, n2_out, n1_out;
  logic [W*2-1:0] d24_out, d2_out, d1_out;
  logic byp24, byp2, byp1;

  ph1_coeff_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_err(cfg_err), .busy(busy),
    .frac_dec_coeff_wr_en(frac_we), .frac_dec_coeff_data_out(frac_out),
    .iir_num_coeff_2_4_wr_en(n24_we), .iir_den_coeff_2_4_wr_en(d24_we),
    .iir_num_coeff_2_wr_en(n2_we), .iir_den_coeff_2_wr_en(d2_we),
    .iir_num_coeff_1_wr_en(n1_we), .iir_den_coeff_1_wr_en(d1_we),
    .iir_num_coeff_2_4_out(n24_out), .iir_num_coeff_2_out(n2_out), .iir_num_coeff_1_out(n1_out),
    .iir_den_coeff_2_4_out(d24_out), .iir_den_coeff_2_out(d2_out), .iir_den_coeff_1_out(d1_out),
    .iir_bypass_2_4(byp24), .iir_bypass_2(byp2), .iir_bypass_1(byp1)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Address order of the shadow words: taps, num/den 2.4, num/den 2, num/den 1.
  wire [WORDS*W-1:0] dut_all = {d1_out, n1_out, d2_out, n2_out, d24_out, n24_out, frac_out};
  wire [7:0] act_mask = {cfg_err, d1_we, n1_we, d2_we, n2_we, d24_we, n24_we, frac_we};

  // Reference model
  int grp_base [7] = '{0, 72, 75, 77, 80, 82, 85};
  logic [W-1:0] m_sh [WORDS];
  logic [6:0] m_dirty;
  logic m_pend;
  logic [2:0] m_byp_sh, m_byp;
  int busy_end;

  typedef struct { int kind; int cyc; } ev_t;  // kind 0..6 = group pulse, 7 = cfg_err
  ev_t evq[$];

  int vectors = 0, errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_shadows();
    int bad = -1;
    for (int i = WORDS - 1; i >= 0; i--)
      if (dut_all[i*W +: W] !== m_sh[i]) bad = i;
    vectors++;
    if (bad >= 0) begin
      errs++;
      $display("FAIL shadow[%0d] @cyc %0d: got %0h expected %0h", bad, cyc, dut_all[bad*W +: W], m_sh[bad]);
    end
  endtask

  function automatic int grp_of(input int a);
    for (int g = 6; g >= 0; g--) if (a >= grp_base[g]) return g;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < WORDS; i++) m_sh[i] = '0;
    m_dirty = '0; m_pend = 1'b0; m_byp_sh = '0; m_byp = '0; busy_end = 0;
    evq.delete();
  endtask

  // One clock of stimulus; checks the live state first, then updates the model.
  task automatic step(input bit v, input int a, input logic [W-1:0] d, input bit c);
    bit rdy;
    rdy = (cyc >= busy_end);
    chk("cfg_ready", cfg_ready, rdy);
    chk("busy", busy, !rdy);
    chk("bypass", {byp1, byp2, byp24}, m_byp);
    chk_shadows();
    if (v && rdy) begin
      if (a < 87) begin
        m_sh[a] = d;
        m_dirty[grp_of(a)] = 1'b1;
      end else if (a == 87) begin
        m_byp_sh = d[2:0];
        m_pend = 1'b1;
      end else begin
        evq.push_back('{kind: 7, cyc: cyc + 1});
      end
    end
    if (c && rdy) begin
      for (int g = 0; g < 7; g++)
        if (m_dirty[g]) evq.push_back('{kind: g, cyc: cyc + 1 + g});
      m_dirty = '0;
      if (m_pend) begin
        m_byp = m_byp_sh;
        m_pend = 1'b0;
      end
      busy_end = cyc + 8;
    end
    cfg_valid = v; cfg_addr = a[7:0]; cfg_data = d; cfg_commit = c;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_pulses", act_mask, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_bypass", {byp1, byp2, byp24}, 3'b000);
    chk_shadows();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: matches every pulse/error against events due in this cycle.
  initial forever begin
    logic [7:0] expm;
    @(negedge clk);
    if (rst_n) begin
      expm = '0;
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].cyc <= cyc) begin
          if (evq[i].cyc == cyc) expm[evq[i].kind] = 1'b1;
          else chk("missed_event", 64'(evq[i].kind), 64'hFF);
          evq.delete(i);
        end
      end
      if (expm != 0 || act_mask != 0) chk("pulse_mask", act_mask, expm);
    end
  end

  initial begin
    model_clear();
    #1;
    do_reset();

    // Full tap bank, values k+1
    for (int k = 0; k < 72; k++) step(1, k, W'(k + 1), 0);
    step(0, 0, '0, 1);
    idle(9);

    // Two denominator words in separate stages, one negative
    step(1, 76, 20'hFFFFB, 0);
    step(1, 85, 20'h7FFFF, 0);
    step(0, 0, '0, 1);
    idle(9);

    // Bypass load, then an empty commit
    step(1, 87, 20'h00005, 0);
    step(0, 0, '0, 1);
    idle(9);
    step(0, 0, '0, 1);
    idle(9);

    // Unmapped write
    step(1, 200, 20'h12345, 0);
    idle(3);

    // Write and commit together; writes and commits during busy are dropped
    step(1, 72, 20'd9, 1);
    step(1, 72, 20'd77, 0);
    step(0, 0, '0, 1);
    step(1, 88, 20'd1, 0);
    idle(6);
    step(0, 0, '0, 1);
    idle(9);

    // Reset in the middle of a walk with every group dirty
    for (int g = 0; g < 7; g++) step(1, grp_base[g], W'(g + 100), 0);
    step(1, 87, 20'h00002, 0);
    step(0, 0, '0, 1);
    idle(2);
    do_reset();
    idle(3);
    step(0, 0, '0, 1);
    idle(9);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      bit v, c;
      int a;
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(88, 255) : $urandom_range(0, 87);
      c = ($urandom_range(0, 9) == 0);
      step(v, a, W'($urandom), c);
    end
    idle(10);

    chk("queue_empty", 64'(evq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
